// File: rtl/load_store_pkg.sv
// load_store_pkg: shared types and saturating step helpers for the load/store volume oscillator
package load_store_pkg;
  typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_e;
  typedef enum logic {TRIANGLE = 1'b0, SAWTOOTH = 1'b1} mode_e;
  // Bounds keep every intermediate inside [lo, hi], so no wrap or underflow can occur
  function automatic int unsigned sat_step(input int unsigned v, input int unsigned step,
                                           input int unsigned lo, input int unsigned hi,
                                           input dir_e d);
    if (d == UP) return (v > hi - step) ? hi : v + step;
    return (v < lo + step) ? lo : v - step;
  endfunction
  function automatic logic in_bounds(input int unsigned v, input int unsigned lo, input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/load_store_chan.sv
// load_store_chan: one oscillator channel holding vol, dir and the registered peak/trough flags
module load_store_chan
  import load_store_pkg::*;
#(
  parameter int unsigned CBITS = 15,
  parameter int unsigned LO    = 0,
  parameter int unsigned HI    = 17500,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  mode_e            mode,
  output logic [CBITS-1:0] vol,
  output logic             sig,
  output logic             bottom,
  output logic             dir
);
  localparam logic [CBITS-1:0] L_LO  = CBITS'(LO);
  localparam logic [CBITS-1:0] L_HI  = CBITS'(HI);
  localparam logic [CBITS+1:0] L_GAP = (CBITS+2)'(2 * (HI - LO) + 2);
  logic [CBITS-1:0] r_vol, w_vol, w_up, w_dn;
  logic [CBITS+1:0] r_gap;
  dir_e             r_dir, w_dir;
  logic             r_sig, r_bot;
  assign w_up = CBITS'(sat_step(32'(r_vol), STEP, LO, HI, UP));
  assign w_dn = CBITS'(sat_step(32'(r_vol), STEP, LO, HI, DOWN));
  always_comb begin
    w_vol = r_vol;
    w_dir = r_dir;
    if (restart) begin
      w_vol = L_LO;
      w_dir = UP;
    end else if (en && mode == SAWTOOTH) begin
      w_dir = UP;
      w_vol = (r_vol >= L_HI) ? L_LO : w_up;
    end else if (en && r_dir == UP) begin
      w_dir = (r_vol >= L_HI) ? DOWN : UP;
      w_vol = (r_vol >= L_HI) ? r_vol : w_up;
    end else if (en) begin
      w_dir = (r_vol <= L_LO) ? UP : DOWN;
      w_vol = (r_vol <= L_LO) ? r_vol : w_dn;
    end
  end
  // Flags come from the next vol so they land in the same cycle as the value they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vol <= L_LO;
      r_dir <= UP;
      r_sig <= (LO == HI);
      r_bot <= 1'b1;
      r_gap <= '0;
    end else begin
      r_vol <= w_vol;
      r_dir <= w_dir;
      r_sig <= (w_vol == L_HI);
      r_bot <= (w_vol == L_LO);
      r_gap <= (restart || r_sig) ? '0 : r_gap + (CBITS+2)'(en);
    end
  end
  assign vol    = r_vol;
  assign sig    = r_sig;
  assign bottom = r_bot;
  assign dir    = r_dir;
  a_range: assert property (@(posedge clk) disable iff (!rst) in_bounds(32'(r_vol), LO, HI));
  a_peak:  assert property (@(posedge clk) disable iff (!rst) r_sig |-> (r_vol == L_HI));
  // Bounded form of liveness: no full ramp can take more enabled cycles than one triangle period
  a_live:  assert property (@(posedge clk) disable iff (!rst) r_gap <= L_GAP);
endmodule

// File: rtl/load_store_multi.sv
// load_store_multi: CHANNELS independent volume oscillators with packed vol and OR-reduced peak flag
module load_store_multi
  import load_store_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CBITS    = 15,
  parameter int unsigned LO       = 0,
  parameter int unsigned HI       = 17500,
  parameter int unsigned STEP     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       restart,
  input  logic                      mode,
  output logic [CHANNELS*CBITS-1:0] vol,
  output logic [CHANNELS-1:0]       sig,
  output logic [CHANNELS-1:0]       bottom,
  output logic [CHANNELS-1:0]       dir,
  output logic                      any_sig
);
  if (!(LO < HI)) begin : g_chk_lohi
    $error("load_store_multi: LO must be below HI");
  end
  if ((HI >> CBITS) != 0) begin : g_chk_width
    $error("load_store_multi: HI does not fit in CBITS");
  end
  if (STEP < 1 || STEP > HI - LO) begin : g_chk_step
    $error("load_store_multi: STEP out of range");
  end
  if (CHANNELS < 1) begin : g_chk_chan
    $error("load_store_multi: CHANNELS must be at least 1");
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    load_store_chan #(.CBITS(CBITS), .LO(LO), .HI(HI), .STEP(STEP)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .restart (restart[g]),
      .mode    (mode_e'(mode)),
      .vol     (vol[g*CBITS +: CBITS]),
      .sig     (sig[g]),
      .bottom  (bottom[g]),
      .dir     (dir[g])
    );
  end
  assign any_sig = |sig;
endmodule

// File: tb/tb_load_store_multi.sv
// tb_load_store_multi: scenario tasks on a small-parameter instance plus a long run on the default one
module tb_load_store_multi;
  localparam int S_LO = 1, S_HI = 5, S_ST = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_s, md_s, any_s;
  logic [1:0] en_s, rs_s, sig_s, bot_s, dir_s;
  logic [7:0] vol_s;
  logic        rst_d, md_d, any_d;
  logic [3:0]  en_d, rs_d, sig_d, bot_d, dir_d;
  logic [59:0] vol_d;
  int total = 0, bad = 0;
  int m_vol [2];
  int m_dir [2];

  load_store_multi #(.CHANNELS(2), .CBITS(4), .LO(S_LO), .HI(S_HI), .STEP(S_ST)) dut_s (
    .clk(clk), .rst(rst_s), .en(en_s), .restart(rs_s), .mode(md_s),
    .vol(vol_s), .sig(sig_s), .bottom(bot_s), .dir(dir_s), .any_sig(any_s));
  load_store_multi dut_d (
    .clk(clk), .rst(rst_d), .en(en_d), .restart(rs_d), .mode(md_d),
    .vol(vol_d), .sig(sig_d), .bottom(bot_d), .dir(dir_d), .any_sig(any_d));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_s;
    en_s = '0; rs_s = '0; md_s = 1'b0; rst_s = 1'b0;
    tick; tick;
    rst_s = 1'b1;
    m_vol = '{S_LO, S_LO};
    m_dir = '{1, 1};
  endtask

  // Reference behaviour: triangle bounces with a hold cycle at each bound, sawtooth wraps to LO
  task automatic model_edge(input logic [1:0] e, input logic [1:0] r, input logic saw);
    for (int i = 0; i < 2; i++) begin
      if (r[i]) begin
        m_vol[i] = S_LO; m_dir[i] = 1;
      end else if (e[i]) begin
        if (saw) begin
          m_dir[i] = 1;
          m_vol[i] = (m_vol[i] >= S_HI) ? S_LO : ((m_vol[i] + S_ST > S_HI) ? S_HI : m_vol[i] + S_ST);
        end else if (m_dir[i] == 1) begin
          if (m_vol[i] >= S_HI) m_dir[i] = 0;
          else m_vol[i] = (m_vol[i] + S_ST > S_HI) ? S_HI : m_vol[i] + S_ST;
        end else begin
          if (m_vol[i] <= S_LO) m_dir[i] = 1;
          else m_vol[i] = (m_vol[i] - S_ST < S_LO) ? S_LO : m_vol[i] - S_ST;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_d = 1'b0; en_d = '0; rs_d = '0; md_d = 1'b0;
    do_reset_s;
    rst_d = 1'b1;
    total++; if (vol_s !== 8'h11) begin bad++; $display("FAIL reset_vol_s got=%h exp=11", vol_s); end
    total++; if (dir_s !== 2'b11) begin bad++; $display("FAIL reset_dir_s got=%b exp=11", dir_s); end
    total++; if (sig_s !== 2'b00 || any_s !== 1'b0) begin bad++; $display("FAIL reset_sig_s got=%b/%b exp=00/0", sig_s, any_s); end
    total++; if (bot_s !== 2'b11) begin bad++; $display("FAIL reset_bot_s got=%b exp=11", bot_s); end
    total++; if (vol_d !== 60'd0 || bot_d !== 4'hf || dir_d !== 4'hf || sig_d !== 4'h0 || any_d !== 1'b0) begin
      bad++; $display("FAIL reset_default got vol=%h bot=%h dir=%h sig=%h any=%b", vol_d, bot_d, dir_d, sig_d, any_d);
    end
  endtask

  task automatic test_triangle;
    int tv [7] = '{3, 5, 5, 3, 1, 1, 3};
    int td [7] = '{1, 1, 0, 0, 0, 1, 1};
    do_reset_s;
    en_s = 2'b11;
    for (int k = 0; k < 7; k++) begin
      tick;
      total++;
      if (vol_s[3:0] !== 4'(tv[k]) || sig_s[0] !== (tv[k] == 5) || bot_s[0] !== (tv[k] == 1) || dir_s[0] !== 1'(td[k])) begin
        bad++; $display("FAIL triangle[%0d] got vol=%0d sig=%b bot=%b dir=%b exp vol=%0d dir=%0d", k, vol_s[3:0], sig_s[0], bot_s[0], dir_s[0], tv[k], td[k]);
      end
    end
  endtask

  task automatic test_sawtooth;
    int tv [6] = '{3, 5, 1, 3, 5, 1};
    do_reset_s;
    en_s = 2'b11; md_s = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      total++;
      if (vol_s[7:4] !== 4'(tv[k]) || sig_s[1] !== (tv[k] == 5) || dir_s !== 2'b11) begin
        bad++; $display("FAIL sawtooth[%0d] got vol=%0d sig=%b dir=%b exp vol=%0d", k, vol_s[7:4], sig_s[1], dir_s, tv[k]);
      end
    end
  endtask

  task automatic test_half_rate;
    do_reset_s;
    for (int c = 0; c < 30; c++) begin
      en_s = {1'(c % 2), 1'b1};
      model_edge(en_s, 2'b00, 1'b0);
      tick;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (vol_s[i*4 +: 4] !== 4'(m_vol[i]) || dir_s[i] !== 1'(m_dir[i])) begin
          bad++; $display("FAIL half_rate c=%0d ch%0d got vol=%0d dir=%b exp vol=%0d dir=%0d", c, i, vol_s[i*4 +: 4], dir_s[i], m_vol[i], m_dir[i]);
        end
      end
      total++;
      if (any_s !== (m_vol[0] == S_HI || m_vol[1] == S_HI)) begin
        bad++; $display("FAIL half_rate_any c=%0d got=%b exp=%b", c, any_s, (m_vol[0] == S_HI || m_vol[1] == S_HI));
      end
    end
  endtask

  task automatic test_restart;
    do_reset_s;
    en_s = 2'b11;
    tick;
    rs_s = 2'b01;
    tick;
    total++; if (vol_s !== 8'h51 || dir_s[0] !== 1'b1 || sig_s !== 2'b10 || bot_s[0] !== 1'b1) begin
      bad++; $display("FAIL restart_peak got vol=%h dir=%b sig=%b bot=%b exp vol=51 sig=10", vol_s, dir_s, sig_s, bot_s);
    end
    total++; if (any_s !== 1'b1) begin bad++; $display("FAIL restart_any got=%b exp=1", any_s); end
    en_s = 2'b00; rs_s = 2'b10;
    tick;
    rs_s = 2'b00;
    total++; if (vol_s !== 8'h11 || dir_s !== 2'b11 || sig_s !== 2'b00 || bot_s !== 2'b11) begin
      bad++; $display("FAIL restart_noen got vol=%h dir=%b sig=%b bot=%b exp vol=11 dir=11 sig=00 bot=11", vol_s, dir_s, sig_s, bot_s);
    end
  endtask

  task automatic test_async_reset;
    do_reset_s;
    en_s = 2'b11;
    tick; tick;
    #2 rst_s = 1'b0;
    #1;
    total++; if (vol_s !== 8'h11 || dir_s !== 2'b11 || sig_s !== 2'b00 || bot_s !== 2'b11 || any_s !== 1'b0) begin
      bad++; $display("FAIL async_reset got vol=%h dir=%b sig=%b bot=%b any=%b exp vol=11", vol_s, dir_s, sig_s, bot_s, any_s);
    end
    #1 rst_s = 1'b1;
    tick;
    total++; if (vol_s !== 8'h33) begin bad++; $display("FAIL async_release got vol=%h exp=33", vol_s); end
  endtask

  task automatic test_random;
    do_reset_s;
    for (int c = 0; c < 400; c++) begin
      en_s = 2'($urandom);
      rs_s = ($urandom % 8 == 0) ? 2'($urandom) : 2'b00;
      if ($urandom % 12 == 0) md_s = ~md_s;
      model_edge(en_s, rs_s, md_s);
      tick;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (vol_s[i*4 +: 4] !== 4'(m_vol[i]) || dir_s[i] !== 1'(m_dir[i]) ||
            sig_s[i] !== (m_vol[i] == S_HI) || bot_s[i] !== (m_vol[i] == S_LO)) begin
          bad++; $display("FAIL random c=%0d ch%0d got vol=%0d dir=%b sig=%b bot=%b exp vol=%0d dir=%0d", c, i, vol_s[i*4 +: 4], dir_s[i], sig_s[i], bot_s[i], m_vol[i], m_dir[i]);
        end
      end
    end
    en_s = '0; rs_s = '0;
  endtask

  task automatic test_default_period;
    int first = -1, second = -1, width = 0, rises = 0, pk = -1;
    logic prev = 1'b0, any_at = 1'b0;
    en_d = 4'hf;
    for (int t = 1; t <= 60000 && rises < 2; t++) begin
      tick;
      if (sig_d[0] && !prev) begin
        if (rises == 0) begin first = t; pk = int'(vol_d[14:0]); any_at = any_d; end
        else second = t;
        rises++;
      end
      if (rises == 1 && sig_d[0]) width++;
      prev = sig_d[0];
    end
    total++; if (first != 17500) begin bad++; $display("FAIL default_first_sig got=%0d exp=17500", first); end
    total++; if (pk != 17500 || any_at !== 1'b1) begin bad++; $display("FAIL default_peak got vol=%0d any=%b exp vol=17500 any=1", pk, any_at); end
    total++; if (width != 2) begin bad++; $display("FAIL default_sig_width got=%0d exp=2", width); end
    total++; if (second - first != 35002) begin bad++; $display("FAIL default_period got=%0d exp=35002", second - first); end
  endtask

  initial begin
    test_reset;
    test_triangle;
    test_sawtooth;
    test_half_rate;
    test_restart;
    test_async_reset;
    test_random;
    test_default_period;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
